// File: rtl/add_sub_pipeline_unit.sv
// Pipelined integer add/subtract unit: one op per cycle in, result plus
// CA/OV/SO/CR0 side results out after PIPE_STAGES register stages, with
// valid/ready back-pressure and flush. Arithmetic sits in front of the first
// register; the remaining stages only carry payload. Bit "0" in PowerPC
// numbering is the MSB, i.e. index DATA_WIDTH-1 here.

package add_sub_pipeline_unit_pkg;

   // Decoded control for one add/sub op
   typedef struct packed {
      logic subtract;
      logic alter_CA;
      logic alter_CR0;
      logic alter_OV;
      logic add_CA;
   } add_sub_decode_t;

endpackage

module add_sub_pipeline_unit
   import add_sub_pipeline_unit_pkg::*;
#(
   parameter int unsigned RS_ID_WIDTH = 5,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [RS_ID_WIDTH-1:0] rs_id_in,
   input  logic [4:0]             result_reg_addr_in,
   input  logic [DATA_WIDTH-1:0]  op1,
   input  logic [DATA_WIDTH-1:0]  op2,
   input  logic                   carry_in,
   input  logic                   so_in,
   input  add_sub_decode_t        control,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [RS_ID_WIDTH-1:0] rs_id_out,
   output logic [4:0]             result_reg_addr_out,
   output logic [DATA_WIDTH-1:0]  result,
   output logic [3:0]             cr0,
   output logic                   ca,
   output logic                   ov,
   output logic                   so,
   output logic                   alter_CR0_out,
   output logic                   alter_CA_out,
   output logic                   alter_OV_out
);

   localparam int unsigned SUM_W = DATA_WIDTH + 1;
   localparam int unsigned MSB   = DATA_WIDTH - 1;

   typedef struct packed {
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             reg_addr;
      logic [DATA_WIDTH-1:0]  result;
      logic [3:0]             cr0;
      logic                   ca;
      logic                   ov;
      logic                   so;
      logic                   alter_cr0;
      logic                   alter_ca;
      logic                   alter_ov;
   } payload_t;

   logic [DATA_WIDTH-1:0]  op_a_c;
   logic                   carry_c;
   logic [SUM_W-1:0]       sum_c;
   logic [DATA_WIDTH-1:0]  res_c;
   logic                   ov_c;
   logic                   so_c;
   payload_t               stage_in_c;
   logic                   advance_c;

   logic [PIPE_STAGES-1:0] stage_valid;
   payload_t               stage_data [PIPE_STAGES];

   // Whole pipe moves as one: advance unless the output holds an unaccepted op
   assign advance_c   = !stage_valid[PIPE_STAGES-1] || output_ready;
   assign input_ready = advance_c;

   // Stage-1 arithmetic and side results for the op at the input
   always_comb begin
      op_a_c  = control.subtract ? ~op1 : op1;
      carry_c = control.add_CA ? carry_in : control.subtract;
      sum_c   = {1'b0, op_a_c} + {1'b0, op2} + SUM_W'(carry_c);
      res_c   = sum_c[MSB:0];
      ov_c    = (op_a_c[MSB] == op2[MSB]) && (res_c[MSB] != op_a_c[MSB]);
      so_c    = control.alter_OV ? (so_in | ov_c) : so_in;

      stage_in_c           = '0;
      stage_in_c.rs_id     = rs_id_in;
      stage_in_c.reg_addr  = result_reg_addr_in;
      stage_in_c.result    = res_c;
      stage_in_c.cr0       = {res_c[MSB], !res_c[MSB] && (res_c != '0), res_c == '0, so_c};
      stage_in_c.ca        = sum_c[DATA_WIDTH];
      stage_in_c.ov        = ov_c;
      stage_in_c.so        = so_c;
      stage_in_c.alter_cr0 = control.alter_CR0;
      stage_in_c.alter_ca  = control.alter_CA;
      stage_in_c.alter_ov  = control.alter_OV;
   end

   // Pipeline registers: payload shifts on advance; flush only kills valids
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_valid <= '0;
         for (int i = 0; i < int'(PIPE_STAGES); i++) begin
            stage_data[i] <= '0;
         end
      end else begin
         if (advance_c) begin
            stage_data[0] <= stage_in_c;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
               stage_data[i] <= stage_data[i-1];
            end
         end
         if (flush) begin
            stage_valid <= '0;
         end else if (advance_c) begin
            stage_valid[0] <= input_valid;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
               stage_valid[i] <= stage_valid[i-1];
            end
         end
      end
   end

   // Outputs come straight from the last stage register
   assign output_valid        = stage_valid[PIPE_STAGES-1];
   assign rs_id_out           = stage_data[PIPE_STAGES-1].rs_id;
   assign result_reg_addr_out = stage_data[PIPE_STAGES-1].reg_addr;
   assign result              = stage_data[PIPE_STAGES-1].result;
   assign cr0                 = stage_data[PIPE_STAGES-1].cr0;
   assign ca                  = stage_data[PIPE_STAGES-1].ca;
   assign ov                  = stage_data[PIPE_STAGES-1].ov;
   assign so                  = stage_data[PIPE_STAGES-1].so;
   assign alter_CR0_out       = stage_data[PIPE_STAGES-1].alter_cr0;
   assign alter_CA_out        = stage_data[PIPE_STAGES-1].alter_ca;
   assign alter_OV_out        = stage_data[PIPE_STAGES-1].alter_ov;

endmodule

// File: tb/tb_add_sub_pipeline_unit.sv
// Bench for add_sub_pipeline_unit: table of hand-computed vectors run through
// PIPE_STAGES=1/2/4 instances, plus stall, flush, reset and 16-bit sequences.
module tb_add_sub_pipeline_unit;
   import add_sub_pipeline_unit_pkg::*;

   typedef struct {
      logic [31:0]     a;
      logic [31:0]     b;
      logic            cin;
      logic            soi;
      add_sub_decode_t ctl;
      logic [31:0]     res;
      logic [3:0]      cr0;
      logic            ca;
      logic            ov;
      logic            so;
   } vec_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic [4:0]  tag;
      logic [4:0]  reg_addr;
      logic [31:0] result;
      logic [3:0]  cr0;
      logic        ca;
      logic        ov;
      logic        so;
      logic [2:0]  alters;
   } obs_t;

   logic clk = 1'b0;
   logic rst, flush, input_valid, output_ready, carry_in, so_in;
   logic aux_ready = 1'b1;
   logic [4:0]  rs_id_in, reg_addr_in;
   logic [31:0] op1, op2;
   logic [15:0] op1_16, op2_16;
   add_sub_decode_t control;

   logic m_ready, m_valid, m_ca, m_ov, m_so, m_acr0, m_aca, m_aov;
   logic [4:0] m_rs_id, m_reg; logic [31:0] m_result; logic [3:0] m_cr0;
   logic a_ready, a_valid, a_ca, a_ov, a_so, a_acr0, a_aca, a_aov;
   logic [4:0] a_rs_id, a_reg; logic [31:0] a_result; logic [3:0] a_cr0;
   logic b_ready, b_valid, b_ca, b_ov, b_so, b_acr0, b_aca, b_aov;
   logic [4:0] b_rs_id, b_reg; logic [31:0] b_result; logic [3:0] b_cr0;
   logic w_ready, w_valid, w_ca, w_ov, w_so, w_acr0, w_aca, w_aov;
   logic [4:0] w_rs_id, w_reg; logic [15:0] w_result; logic [3:0] w_cr0;

   int checks = 0;
   int errors = 0;
   logic [31:0] cyc = 32'd0;
   logic [31:0] acc_cyc [32];
   obs_t q_main[$], q_p1[$], q_p4[$], q_w16[$];
   vec_t vecs [6];
   logic hold_en = 1'b0;
   logic stalled_prev = 1'b0;
   logic [63:0] prev_snap = 64'd0;
   int stall_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   add_sub_pipeline_unit #(.RS_ID_WIDTH(5), .DATA_WIDTH(32), .PIPE_STAGES(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .input_valid(input_valid), .input_ready(m_ready),
      .rs_id_in(rs_id_in), .result_reg_addr_in(reg_addr_in), .op1(op1), .op2(op2),
      .carry_in(carry_in), .so_in(so_in), .control(control), .output_valid(m_valid),
      .output_ready(output_ready), .rs_id_out(m_rs_id), .result_reg_addr_out(m_reg),
      .result(m_result), .cr0(m_cr0), .ca(m_ca), .ov(m_ov), .so(m_so),
      .alter_CR0_out(m_acr0), .alter_CA_out(m_aca), .alter_OV_out(m_aov));

   add_sub_pipeline_unit #(.RS_ID_WIDTH(5), .DATA_WIDTH(32), .PIPE_STAGES(1)) dut_p1 (
      .clk(clk), .rst(rst), .flush(flush), .input_valid(input_valid), .input_ready(a_ready),
      .rs_id_in(rs_id_in), .result_reg_addr_in(reg_addr_in), .op1(op1), .op2(op2),
      .carry_in(carry_in), .so_in(so_in), .control(control), .output_valid(a_valid),
      .output_ready(aux_ready), .rs_id_out(a_rs_id), .result_reg_addr_out(a_reg),
      .result(a_result), .cr0(a_cr0), .ca(a_ca), .ov(a_ov), .so(a_so),
      .alter_CR0_out(a_acr0), .alter_CA_out(a_aca), .alter_OV_out(a_aov));

   add_sub_pipeline_unit #(.RS_ID_WIDTH(5), .DATA_WIDTH(32), .PIPE_STAGES(4)) dut_p4 (
      .clk(clk), .rst(rst), .flush(flush), .input_valid(input_valid), .input_ready(b_ready),
      .rs_id_in(rs_id_in), .result_reg_addr_in(reg_addr_in), .op1(op1), .op2(op2),
      .carry_in(carry_in), .so_in(so_in), .control(control), .output_valid(b_valid),
      .output_ready(aux_ready), .rs_id_out(b_rs_id), .result_reg_addr_out(b_reg),
      .result(b_result), .cr0(b_cr0), .ca(b_ca), .ov(b_ov), .so(b_so),
      .alter_CR0_out(b_acr0), .alter_CA_out(b_aca), .alter_OV_out(b_aov));

   add_sub_pipeline_unit #(.RS_ID_WIDTH(5), .DATA_WIDTH(16), .PIPE_STAGES(2)) dut_w16 (
      .clk(clk), .rst(rst), .flush(flush), .input_valid(input_valid), .input_ready(w_ready),
      .rs_id_in(rs_id_in), .result_reg_addr_in(reg_addr_in), .op1(op1_16), .op2(op2_16),
      .carry_in(carry_in), .so_in(so_in), .control(control), .output_valid(w_valid),
      .output_ready(aux_ready), .rs_id_out(w_rs_id), .result_reg_addr_out(w_reg),
      .result(w_result), .cr0(w_cr0), .ca(w_ca), .ov(w_ov), .so(w_so),
      .alter_CR0_out(w_acr0), .alter_CA_out(w_aca), .alter_OV_out(w_aov));

   function automatic logic [63:0] snap();
      return 64'({m_valid, m_rs_id, m_reg, m_result, m_cr0, m_ca, m_ov, m_so, m_acr0, m_aca, m_aov});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Main DUT: acceptance times, delivered results, and stall stability
   always @(negedge clk) begin
      if (input_valid && m_ready && !flush && !rst) acc_cyc[rs_id_in] = cyc + 32'd1;
      if (hold_en && stalled_prev) chk("stall_hold", snap(), prev_snap);
      if (hold_en && !m_ready) stall_cnt++;
      stalled_prev = m_valid && !output_ready;
      prev_snap = snap();
      if (m_valid && output_ready)
         q_main.push_back('{cyc, m_rs_id, m_reg, m_result, m_cr0, m_ca, m_ov, m_so, {m_acr0, m_aca, m_aov}});
   end

   // Auxiliary DUTs always drain
   always @(negedge clk) begin
      if (a_valid) q_p1.push_back('{cyc, a_rs_id, a_reg, a_result, a_cr0, a_ca, a_ov, a_so, {a_acr0, a_aca, a_aov}});
      if (b_valid) q_p4.push_back('{cyc, b_rs_id, b_reg, b_result, b_cr0, b_ca, b_ov, b_so, {b_acr0, b_aca, b_aov}});
      if (w_valid) q_w16.push_back('{cyc, w_rs_id, w_reg, 32'(w_result), w_cr0, w_ca, w_ov, w_so, {w_acr0, w_aca, w_aov}});
   end

   task automatic send(input int vi, input logic [4:0] tag);
      int n;
      op1 = vecs[vi].a; op2 = vecs[vi].b; carry_in = vecs[vi].cin;
      so_in = vecs[vi].soi; control = vecs[vi].ctl;
      rs_id_in = tag; reg_addr_in = 5'(tag + 5'd10); input_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL send_timeout: tag %0d never accepted, expected acceptance within 50 cycles", tag);
      end
      @(posedge clk); #1;
      input_valid = 1'b0;
   endtask

   task automatic chk_obs(input string who, input obs_t o, input int vi, input logic [4:0] tag, input int lat);
      chk({who, "_tag"}, 64'(o.tag), 64'(tag));
      chk({who, "_reg"}, 64'(o.reg_addr), 64'(5'(tag + 5'd10)));
      chk({who, "_result"}, 64'(o.result), 64'(vecs[vi].res));
      chk({who, "_cr0"}, 64'(o.cr0), 64'(vecs[vi].cr0));
      chk({who, "_ca_ov_so"}, 64'({o.ca, o.ov, o.so}), 64'({vecs[vi].ca, vecs[vi].ov, vecs[vi].so}));
      chk({who, "_alters"}, 64'(o.alters),
          64'({vecs[vi].ctl.alter_CR0, vecs[vi].ctl.alter_CA, vecs[vi].ctl.alter_OV}));
      if (lat >= 0) chk({who, "_latency"}, 64'(o.cyc - acc_cyc[tag]), 64'(lat));
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      // control = {subtract, alter_CA, alter_CR0, alter_OV, add_CA}
      vecs[0] = '{32'd89, 32'd187, 1'b1, 1'b0, add_sub_decode_t'(5'b00100), 32'd276, 4'b0100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'd89, 32'd187, 1'b0, 1'b0, add_sub_decode_t'(5'b11100), 32'd98, 4'b0100, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{32'h7FFF_FFFE, 32'd5, 1'b0, 1'b0, add_sub_decode_t'(5'b01110), 32'h8000_0003, 4'b1001, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, add_sub_decode_t'(5'b01101), 32'd0, 4'b0010, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{32'd1, 32'd1, 1'b0, 1'b1, add_sub_decode_t'(5'b00110), 32'd2, 4'b0101, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'd5, 32'd3, 1'b0, 1'b0, add_sub_decode_t'(5'b11100), 32'hFFFF_FFFE, 4'b1000, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; flush = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
      rs_id_in = '0; reg_addr_in = '0; op1 = '0; op2 = '0; op1_16 = '0; op2_16 = '0;
      carry_in = 1'b0; so_in = 1'b0; control = '0;
      for (int i = 0; i < 32; i++) acc_cyc[i] = 32'd0;

      // Reset state
      repeat (2) @(posedge clk); #1;
      chk("reset_outputs", snap(), 64'd0);
      chk("reset_input_ready", 64'(m_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_ready", 64'(m_ready), 64'd1);
      chk("post_reset_valid", 64'(m_valid), 64'd0);

      // Back-to-back ops, all instances
      q_main.delete(); q_p1.delete(); q_p4.delete();
      for (int i = 0; i < 6; i++) send(i, 5'(i));
      drain();
      chk("s1_main_count", 64'(q_main.size()), 64'd6);
      chk("s1_p1_count", 64'(q_p1.size()), 64'd6);
      chk("s1_p4_count", 64'(q_p4.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < q_main.size()) chk_obs("s1_p2", q_main[i], i, 5'(i), 1);
         if (i < q_p1.size())   chk_obs("s1_p1", q_p1[i], i, 5'(i), 0);
         if (i < q_p4.size())   chk_obs("s1_p4", q_p4[i], i, 5'(i), 3);
      end

      // Same ops with output_ready low for three cycles
      q_main.delete(); stall_cnt = 0; hold_en = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) send(i, 5'(i));
         end
         begin
            repeat (2) @(posedge clk); #1;
            output_ready = 1'b0;
            repeat (3) @(posedge clk); #1;
            output_ready = 1'b1;
         end
      join
      drain();
      hold_en = 1'b0;
      chk("s2_stall_cycles", 64'(stall_cnt), 64'd3);
      chk("s2_count", 64'(q_main.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         if (i < q_main.size()) chk_obs("s2", q_main[i], i, 5'(i), -1);

      // Flush while the output is stalled and a new op is presented
      q_main.delete();
      send(0, 5'd0);
      send(1, 5'd1);
      output_ready = 1'b0; flush = 1'b1;
      op1 = vecs[2].a; op2 = vecs[2].b; carry_in = vecs[2].cin; so_in = vecs[2].soi;
      control = vecs[2].ctl; rs_id_in = 5'd2; reg_addr_in = 5'd12; input_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
      @(negedge clk);
      chk("s3_flush_valid", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      send(3, 5'd3);
      drain();
      chk("s3_count", 64'(q_main.size()), 64'd1);
      if (q_main.size() > 0) chk_obs("s3", q_main[0], 3, 5'd3, 1);

      // Async reset between edges with two ops in flight
      q_main.delete();
      output_ready = 1'b0;
      send(4, 5'd4);
      send(5, 5'd5);
      @(negedge clk);
      chk("s4_pre_valid", 64'(m_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("s4_reset_outputs", snap(), 64'd0);
      chk("s4_reset_ready", 64'(m_ready), 64'd1);
      rst = 1'b0;
      output_ready = 1'b1;
      drain();
      chk("s4_no_output", 64'(q_main.size()), 64'd0);

      // 16-bit instance overflow
      q_w16.delete();
      op1_16 = 16'h7FFE; op2_16 = 16'd5;
      send(2, 5'd7);
      drain();
      chk("w16_count", 64'(q_w16.size()), 64'd1);
      if (q_w16.size() > 0) begin
         chk("w16_result", 64'(q_w16[0].result), 64'h8003);
         chk("w16_cr0", 64'(q_w16[0].cr0), 64'b1001);
         chk("w16_ca_ov_so", 64'({q_w16[0].ca, q_w16[0].ov, q_w16[0].so}), 64'b011);
         chk("w16_latency", 64'(q_w16[0].cyc - acc_cyc[7]), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
